// File: rtl/radix2_div_pkg.sv
// Shared definitions for the radix-2 restoring divider: FSM encodings and
// named control/result constants.
package radix2_div_pkg;

    typedef enum logic [1:0] {
        DivFree   = 2'b00,
        DivByZero = 2'b01,
        DivOn     = 2'b10,
        DivEnd    = 2'b11
    } div_state_e;

    localparam logic DivStart          = 1'b1;
    localparam logic DivStop           = 1'b0;
    localparam logic DivResultReady    = 1'b1;
    localparam logic DivResultNotReady = 1'b0;

    localparam logic [31:0] ZeroWord = 32'h0000_0000;

endpackage

// File: rtl/radix2_div_step.sv
// One restoring shift-subtract iteration: shifts the next dividend bit into
// the partial remainder and subtracts the divisor when it fits.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic             bit_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_out,
    output logic             quo_bit
);

    logic [WIDTH:0] trial;
    logic [WIDTH:0] diff;

    assign trial = {rem_in, bit_in};
    assign diff  = trial - {1'b0, divisor};

    // rem_in < divisor keeps trial below 2*divisor, so diff's MSB is a clean borrow flag.
    assign quo_bit = ~diff[WIDTH];
    assign rem_out = quo_bit ? diff[WIDTH-1:0] : trial[WIDTH-1:0];

endmodule

// File: rtl/radix2_div.sv
// Multi-cycle signed/unsigned divider: one quotient bit per clock, result is
// {remainder, quotient} held while start stays high.
module radix2_div
    import radix2_div_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               signed_div,
    input  logic [WIDTH-1:0]   opdata1,
    input  logic [WIDTH-1:0]   opdata2,
    input  logic               start,
    input  logic               annul,
    output logic [2*WIDTH-1:0] result,
    output logic               ready
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0]   LAST_CNT = CNT_W'(WIDTH);
    localparam logic [WIDTH-1:0]   ZERO_W   = WIDTH'(ZeroWord);
    localparam logic [2*WIDTH-1:0] ZERO_R   = {ZERO_W, ZERO_W};

    div_state_e         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic [WIDTH-1:0]   dvd_q, dvd_d;       // dividend shifts out as quotient shifts in
    logic [WIDTH-1:0]   dsr_q, dsr_d;
    logic               neg_quo_q, neg_quo_d;
    logic               neg_rem_q, neg_rem_d;
    logic [2*WIDTH-1:0] result_q, result_d;
    logic               ready_q, ready_d;
    logic [WIDTH-1:0]   step_rem;
    logic               step_q;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_in  (rem_q),
        .bit_in  (dvd_q[WIDTH-1]),
        .divisor (dsr_q),
        .rem_out (step_rem),
        .quo_bit (step_q)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        dvd_d     = dvd_q;
        dsr_d     = dsr_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        result_d  = result_q;
        ready_d   = ready_q;
        unique case (state_q)
            DivFree: begin
                ready_d  = DivResultNotReady;
                result_d = ZERO_R;
                if (start == DivStart && !annul) begin
                    cnt_d     = '0;
                    rem_d     = ZERO_W;
                    // 0x80..0 negates to itself, which is the correct unsigned magnitude.
                    dvd_d     = (signed_div && opdata1[WIDTH-1]) ? ZERO_W - opdata1 : opdata1;
                    dsr_d     = (signed_div && opdata2[WIDTH-1]) ? ZERO_W - opdata2 : opdata2;
                    neg_quo_d = signed_div & (opdata1[WIDTH-1] ^ opdata2[WIDTH-1]);
                    neg_rem_d = signed_div & opdata1[WIDTH-1];
                    state_d   = (opdata2 == ZERO_W) ? DivByZero : DivOn;
                end
            end
            DivByZero: begin
                result_d = ZERO_R;
                if (annul) begin
                    ready_d = DivResultNotReady;
                    state_d = DivFree;
                end else begin
                    ready_d = DivResultReady;
                    state_d = DivEnd;
                end
            end
            DivOn: begin
                if (annul) begin
                    cnt_d    = '0;
                    result_d = ZERO_R;
                    ready_d  = DivResultNotReady;
                    state_d  = DivFree;
                end else if (cnt_q != LAST_CNT) begin
                    rem_d = step_rem;
                    dvd_d = {dvd_q[WIDTH-2:0], step_q};
                    cnt_d = cnt_q + CNT_W'(1);
                end else begin
                    result_d = {neg_rem_q ? ZERO_W - rem_q : rem_q,
                                neg_quo_q ? ZERO_W - dvd_q : dvd_q};
                    ready_d  = DivResultReady;
                    state_d  = DivEnd;
                end
            end
            DivEnd: begin
                if (start == DivStop) begin
                    result_d = ZERO_R;
                    ready_d  = DivResultNotReady;
                    state_d  = DivFree;
                end
            end
            default: begin
                result_d = ZERO_R;
                ready_d  = DivResultNotReady;
                state_d  = DivFree;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= DivFree;
            cnt_q     <= '0;
            rem_q     <= ZERO_W;
            dvd_q     <= ZERO_W;
            dsr_q     <= ZERO_W;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            result_q  <= ZERO_R;
            ready_q   <= DivResultNotReady;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            dvd_q     <= dvd_d;
            dsr_q     <= dsr_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            result_q  <= result_d;
            ready_q   <= ready_d;
        end
    end

    assign result = result_q;
    assign ready  = ready_q;

endmodule
